// File: rtl/intra4x4_pkg.sv
// rtl/intra4x4_pkg.sv - shared types and constants for the intra 4x4 luma mode decision
//
// Purpose: H.264 intra4x4 mode numbers, the order in which the mode decision
// walks its residual buffer, FSM states, datapath widths and an 8-bit
// magnitude helper.
// Ports: none (package).
package intra4x4_pkg;

  localparam int NUM_MODES = 8;
  localparam int NUM_PIX   = 16;
  localparam int SAD_W_DEF = 12;

  typedef enum logic [3:0] {
    MODE_V   = 4'd0,
    MODE_H   = 4'd1,
    MODE_DC  = 4'd2,
    MODE_DDL = 4'd3,
    MODE_DDR = 4'd4,
    MODE_VR  = 4'd5,
    MODE_HD  = 4'd6,
    MODE_VL  = 4'd7,
    MODE_HU  = 4'd8
  } intra4x4_mode_e;

  // Slot k of the residual buffer holds the mode EVAL_ORDER[k]. The order is
  // ascending in mode number, so a strict less-than compare makes the lowest
  // mode number win ties.
  localparam logic [NUM_MODES-1:0][3:0] EVAL_ORDER = {
    MODE_HU, MODE_VL, MODE_HD, MODE_VR, MODE_DDR, MODE_DDL, MODE_H, MODE_V
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // |v| of a signed byte; 9 bits so that |-128| = 128 is representable.
  function automatic logic [8:0] abs8(input logic [7:0] v);
    logic [8:0] ext;
    ext = {v[7], v};
    return v[7] ? 9'(9'd0 - ext) : ext;
  endfunction

endpackage

// File: rtl/abs_sum_lanes.sv
// rtl/abs_sum_lanes.sv - combinational sum of absolute values across LANES signed bytes
//
// Purpose: one chunk of SAD accumulation for the mode decision.
// Ports:
//   pix  in  [LANES-1:0][7:0]  signed residual bytes
//   sum  out [SAD_W-1:0]       sum of their magnitudes, zero-extended
module abs_sum_lanes
  import intra4x4_pkg::*;
#(
  parameter int LANES = 4,
  parameter int SAD_W = SAD_W_DEF
) (
  input  logic [LANES-1:0][7:0] pix,
  output logic [SAD_W-1:0]      sum
);

  always_comb begin
    sum = '0;
    for (int l = 0; l < LANES; l++) begin
      sum = sum + SAD_W'(abs8(pix[l]));
    end
  end

endmodule

// File: rtl/mode_select_luma4x4.sv
// rtl/mode_select_luma4x4.sv - intra 4x4 luma mode decision by minimum SAD (optional cost: MODE_COST_EN)
//
// Purpose: on start, snapshot the eight residual blocks, accumulate a SAD per
// mode LANES pixels per cycle, and report the cheapest mode with a done pulse.
// Build option: define MODE_COST_EN to add a rate penalty of 4*lambda to
// every mode other than pred_mode.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 one-cycle request, taken only when idle
//   vres .. ddrres        16 signed 8-bit residuals each, raster order
//   pred_mode, lambda     (MODE_COST_EN only) sampled with the residuals
//   busy                  high from the capture edge until done
//   done                  one-cycle pulse, results valid
//   best_mode, best_sad   winning H.264 mode number and its cost
module mode_select_luma4x4
  import intra4x4_pkg::*;
#(
  parameter int LANES = 4,
  parameter int SAD_W = SAD_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_PIX-1:0][7:0]   vres,
  input  logic [NUM_PIX-1:0][7:0]   hres,
  input  logic [NUM_PIX-1:0][7:0]   vlres,
  input  logic [NUM_PIX-1:0][7:0]   vrres,
  input  logic [NUM_PIX-1:0][7:0]   hures,
  input  logic [NUM_PIX-1:0][7:0]   hdres,
  input  logic [NUM_PIX-1:0][7:0]   ddlres,
  input  logic [NUM_PIX-1:0][7:0]   ddrres,
`ifdef MODE_COST_EN
  input  logic [3:0]                pred_mode,
  input  logic [7:0]                lambda,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [3:0]                best_mode,
  output logic [SAD_W-1:0]          best_sad
);

  localparam logic [4:0] LAST_BASE = 5'(NUM_PIX - LANES);
  localparam logic [4:0] STEP      = 5'(LANES);

  state_e            state, next_state;
  logic              capture, step;
  logic [4:0]        pix_base;
  logic [2:0]        mode_idx;
  logic [SAD_W-1:0]  acc;
  logic [7:0]        res_buf [NUM_MODES][NUM_PIX];

  logic              last_chunk, last_mode;
  logic [3:0]        cur_mode;
  logic [LANES-1:0][7:0] lane_pix;
  logic [SAD_W-1:0]  chunk_sum, sad_total, penalty, cost;

`ifdef MODE_COST_EN
  logic [3:0]        pred_q;
  logic [7:0]        lambda_q;
`endif

  assign last_chunk = (pix_base == LAST_BASE);
  assign last_mode  = (mode_idx == 3'(NUM_MODES - 1));
  assign cur_mode   = EVAL_ORDER[mode_idx];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next state and datapath strobes
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    step       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          capture    = 1'b1;
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last_chunk && last_mode) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Residual snapshot, slot order follows EVAL_ORDER. Contents are don't-care
  // until the first capture, so no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < NUM_PIX; i++) begin
        res_buf[0][i] <= vres[i];
        res_buf[1][i] <= hres[i];
        res_buf[2][i] <= ddlres[i];
        res_buf[3][i] <= ddrres[i];
        res_buf[4][i] <= vrres[i];
        res_buf[5][i] <= hdres[i];
        res_buf[6][i] <= vlres[i];
        res_buf[7][i] <= hures[i];
      end
    end
  end

  always_comb begin
    lane_pix = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_pix[l] = res_buf[mode_idx][pix_base[3:0] + 4'(l)];
    end
  end

  abs_sum_lanes #(
    .LANES (LANES),
    .SAD_W (SAD_W)
  ) u_abs_sum (
    .pix (lane_pix),
    .sum (chunk_sum)
  );

  assign sad_total = acc + chunk_sum;

`ifdef MODE_COST_EN
  assign penalty = (cur_mode == pred_q) ? '0 : SAD_W'({lambda_q, 2'b00});
`else
  assign penalty = '0;
`endif

  assign cost = sad_total + penalty;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      best_mode <= 4'd0;
      best_sad  <= '0;
      acc       <= '0;
      pix_base  <= '0;
      mode_idx  <= '0;
`ifdef MODE_COST_EN
      pred_q    <= '0;
      lambda_q  <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (capture) begin
        busy     <= 1'b1;
        acc      <= '0;
        best_sad <= '1;
        pix_base <= '0;
        mode_idx <= '0;
`ifdef MODE_COST_EN
        pred_q   <= pred_mode;
        lambda_q <= lambda;
`endif
      end else if (step) begin
        if (last_chunk) begin
          if (cost < best_sad) begin
            best_sad  <= cost;
            best_mode <= cur_mode;
          end
          acc      <= '0;
          pix_base <= '0;
          mode_idx <= mode_idx + 3'd1;
          if (last_mode) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end else begin
          acc      <= sad_total;
          pix_base <= pix_base + STEP;
        end
      end
    end
  end

endmodule

// File: tb/tb_mode_select_luma4x4.sv
// tb/tb_mode_select_luma4x4.sv - self-checking bench for mode_select_luma4x4
module tb_mode_select_luma4x4;

  localparam int LANES = 4;
  localparam int SAD_W = 12;
  localparam int LAT   = 128 / LANES;
  localparam int BOUND = 200;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [15:0][7:0] vres, hres, vlres, vrres, hures, hdres, ddlres, ddrres;
  logic busy, done;
  logic [3:0] best_mode;
  logic [SAD_W-1:0] best_sad;
`ifdef MODE_COST_EN
  logic [3:0] pred_mode;
  logic [7:0] lambda;
  localparam bit COST_EN = 1'b1;
`else
  localparam bit COST_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_err    = 0;

  // r[m][i]: residual i of H.264 mode number m (row 2 = DC, unused)
  int r [9][16];
  int tb_pred = 0;
  int tb_lam  = 0;

  always #5 clk = ~clk;

  mode_select_luma4x4 #(.LANES(LANES), .SAD_W(SAD_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .vres      (vres),
    .hres      (hres),
    .vlres     (vlres),
    .vrres     (vrres),
    .hures     (hures),
    .hdres     (hdres),
    .ddlres    (ddlres),
    .ddrres    (ddrres),
`ifdef MODE_COST_EN
    .pred_mode (pred_mode),
    .lambda    (lambda),
`endif
    .busy      (busy),
    .done      (done),
    .best_mode (best_mode),
    .best_sad  (best_sad)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 16; i++) begin
      vres[i]   = 8'(r[0][i]);
      hres[i]   = 8'(r[1][i]);
      ddlres[i] = 8'(r[3][i]);
      ddrres[i] = 8'(r[4][i]);
      vrres[i]  = 8'(r[5][i]);
      hdres[i]  = 8'(r[6][i]);
      vlres[i]  = 8'(r[7][i]);
      hures[i]  = 8'(r[8][i]);
    end
`ifdef MODE_COST_EN
    pred_mode = 4'(tb_pred);
    lambda    = 8'(tb_lam);
`endif
  endtask

  task automatic fill_const(input int m, input int v);
    for (int i = 0; i < 16; i++) r[m][i] = v;
  endtask

  task automatic fill_all(input int v);
    for (int m = 0; m < 9; m++) fill_const(m, v);
  endtask

  task automatic fill_random();
    for (int m = 0; m < 9; m++)
      for (int i = 0; i < 16; i++)
        r[m][i] = int'($urandom_range(0, 255)) - 128;
  endtask

  // Cheapest mode by plain arithmetic; scanning in increasing mode number
  // with strict < gives ties to the lowest number.
  task automatic model(output int bm, output int bs);
    bm = -1;
    bs = 32'h7fffffff;
    for (int m = 0; m < 9; m++) begin
      int sad;
      int c;
      if (m == 2) continue;
      sad = 0;
      for (int i = 0; i < 16; i++) sad += (r[m][i] < 0) ? -r[m][i] : r[m][i];
      c = sad + ((COST_EN && m != tb_pred) ? 4 * tb_lam : 0);
      if (c < bs) begin
        bs = c;
        bm = m;
      end
    end
  endtask

  task automatic run(input string tag, input int poke_at);
    int k, busy_cnt, em, es, extra;
    model(em, es);
    apply();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    busy_cnt = 0;
    while (!done && k <= BOUND) begin
      if (busy) busy_cnt++;
      if (k == poke_at) begin
        fill_random();
        apply();
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({tag, "_latency"}, k, LAT);
    check({tag, "_busy_cycles"}, busy_cnt, LAT);
    check({tag, "_busy_at_done"}, int'(busy), 0);
    check({tag, "_best_mode"}, int'(best_mode), em);
    check({tag, "_best_sad"}, int'(best_sad), es);
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check({tag, "_extra_done"}, extra, 0);
    check({tag, "_hold_mode"}, int'(best_mode), em);
    check({tag, "_hold_sad"}, int'(best_sad), es);
  endtask

  initial begin
    int extra;
    reset = 1'b1;
    start = 1'b0;
    fill_all(0);
    apply();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_best_mode", int'(best_mode), 0);
    check("reset_best_sad", int'(best_sad), 0);

    // All-zero residuals: V wins with cost 0.
    fill_all(0);
    run("zeros", -1);

    // H is the only zero-cost mode.
    fill_all(1);
    fill_const(1, 0);
    run("h_zero", -1);

    // V at SAD 2048 loses; the other seven tie at 2032 and H takes the tie.
    fill_all(127);
    fill_const(0, -128);
    run("neg128_tie", -1);

    // Start while busy must be ignored; the snapshot decides.
    fill_all(3);
    fill_const(8, 2);
    run("hu_poke", 10);

    // Reset in the middle of RUN: no done, outputs back to zero.
    fill_random();
    apply();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_best_mode", int'(best_mode), 0);
    check("midreset_best_sad", int'(best_sad), 0);
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("midreset_no_done", extra, 0);
    fill_random();
    run("after_reset", -1);

    // Random blocks, some with a duplicated block to force ties.
    for (int t = 0; t < 8; t++) begin
      fill_random();
      if (t % 2 == 1) begin
        int a, b;
        a = int'($urandom_range(0, 8));
        b = int'($urandom_range(0, 8));
        if (a == 2) a = 0;
        if (b == 2) b = 8;
        for (int i = 0; i < 16; i++) r[b][i] = r[a][i];
      end
      if (t == 6) for (int i = 0; i < 16; i++) r[5][i] = (i % 2 == 0) ? -128 : 127;
      run($sformatf("rand%0d", t), (t == 3) ? 5 : -1);
    end

`ifdef MODE_COST_EN
    fill_all(0);
    for (int i = 0; i < 8; i++) begin
      r[1][i] = 25; r[3][i] = -25; r[4][i] = 25; r[5][i] = -25;
      r[6][i] = 25; r[7][i] = -25;
    end
    for (int i = 8; i < 16; i++) begin
      r[1][i] = -25; r[3][i] = 25; r[4][i] = -25; r[5][i] = 25;
      r[6][i] = -25; r[7][i] = 25;
    end
    for (int i = 0; i < 5; i++) r[0][i] = 10;
    for (int i = 0; i < 3; i++) r[8][i] = -10;
    tb_pred = 8; tb_lam = 10;
    run("cost_pred_hu", -1);
    check("cost_pred_hu_const", int'(best_mode), 8);
    tb_pred = 0; tb_lam = 0;
    run("cost_lambda0", -1);
    check("cost_lambda0_const", int'(best_sad), 30);
    tb_pred = 0; tb_lam = 10;
    run("cost_pred_v", -1);
    check("cost_pred_v_const", int'(best_sad), 50);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
